latch_bank_write_arbiter: RTL and testbench



---
 rtl/latch_bank_write_arbiter.sv | 117 +++++++++++
 tb/tb_latch_bank_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter for a bank of D-latch words: grants one requester at a time
// and sequences shared data and one-hot gate enables through setup / pulse / hold.
module latch_bank_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2,
    parameter int PULSE  = 2,
    localparam int DEPTH = 2 ** ADDR_W,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic [WIDTH-1:0]         lat_d,
    output logic [DEPTH-1:0]         lat_c
);

    localparam int CNT_W = (PULSE > 1) ? $clog2(PULSE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [ID_W-1:0]   rr_ptr;

    logic              win_valid;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   scan_idx;

    logic [DEPTH-1:0]  lat_c_nxt;
    logic [NREQ-1:0]   ack_nxt;
    logic [WIDTH-1:0]  lat_d_nxt;

    // Scan requesters starting at rr_ptr; the first one found wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        win_valid = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (!win_valid && req[scan_idx]) begin
                win_valid = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_valid) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_PULSE;
            S_PULSE: if (cnt == '0) state_nxt = S_HOLD;
            S_HOLD:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the pins come straight from flops.
    always_comb begin
        lat_c_nxt = '0;
        ack_nxt   = '0;
        lat_d_nxt = lat_d;
        if (state_nxt == S_PULSE)
            lat_c_nxt = DEPTH'(1) << cap_addr;
        if (state_nxt == S_DONE)
            ack_nxt = NREQ'(1) << grant_id;
        if (state == S_IDLE && win_valid)
            lat_d_nxt = req_data[int'(win_id)*WIDTH +: WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            lat_d    <= '0;
            lat_c    <= '0;
            ack      <= '0;
        end else begin
            state <= state_nxt;
            lat_d <= lat_d_nxt;
            lat_c <= lat_c_nxt;
            ack   <= ack_nxt;
            if (state == S_IDLE && win_valid) begin
                cap_addr <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                grant_id <= win_id;
                rr_ptr   <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
            end
            if (state == S_SETUP)
                cnt <= CNT_W'(PULSE - 1);
            else if (state == S_PULSE && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Bench for latch_bank_write_arbiter: a cycle-offset model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_latch_bank_write_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 2;
    localparam int PULSE  = 2;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int ID_W   = 2;
    localparam int LAST   = PULSE + 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*WIDTH-1:0]  req_data = '0;
    logic [NREQ-1:0]        ack;
    logic                   busy;
    logic [ID_W-1:0]        grant_id;
    logic [WIDTH-1:0]       lat_d;
    logic [DEPTH-1:0]       lat_c;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    latch_bank_write_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .PULSE(PULSE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .busy(busy), .grant_id(grant_id), .lat_d(lat_d), .lat_c(lat_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Model: m_t counts cycles since the grant (0 = idle); outputs follow from that offset.
    int m_t, m_ptr, m_gid, m_addr, m_data, m_win;
    bit m_fresh;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    always_comb m_win = rr_pick(req, m_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_ptr <= 0; m_gid <= 0; m_addr <= 0; m_data <= 0; m_fresh <= 1'b1;
        end else if (m_t == 0) begin
            if (req != '0) begin
                m_t     <= 1;
                m_gid   <= m_win;
                m_addr  <= int'(req_addr[m_win*ADDR_W +: ADDR_W]);
                m_data  <= int'(req_data[m_win*WIDTH +: WIDTH]);
                m_ptr   <= (m_win + 1) % NREQ;
                m_fresh <= 1'b0;
            end
        end else if (m_t == LAST) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    int ack_ids[$];
    int ack_cyc[$];
    logic [DEPTH-1:0] pulses[$];
    logic [DEPTH-1:0] prev_lat_c = '0;

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_t != 0));
        check("lat_c", 32'(lat_c), (m_t >= 2 && m_t <= PULSE + 1) ? (32'd1 << m_addr) : 32'd0);
        check("ack", 32'(ack), (m_t == LAST) ? (32'd1 << m_gid) : 32'd0);
        check("grant_id", 32'(grant_id), 32'(m_gid));
        if (m_t >= 1 && m_t <= PULSE + 2) check("lat_d", 32'(lat_d), 32'(m_data));
        else if (m_fresh) check("lat_d_rst", 32'(lat_d), 32'd0);
        for (int i = 0; i < NREQ; i++)
            if (ack[i]) begin
                ack_ids.push_back(i);
                ack_cyc.push_back(cyc);
            end
        if (lat_c != '0 && prev_lat_c == '0) pulses.push_back(lat_c);
        prev_lat_c <= lat_c;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int i, input int addr, input int data);
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        req_data[i*WIDTH +: WIDTH]   = WIDTH'(data);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_lat_c"}, 32'(lat_c), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_lat_d"}, 32'(lat_d), 32'd0);
        check({tag, "_gid"}, 32'(grant_id), 32'd0);
    endtask

    task automatic clear_logs();
        ack_ids.delete();
        ack_cyc.delete();
        pulses.delete();
    endtask

    initial begin
        // Reset held with random inputs.
        req = NREQ'($urandom); req_addr = $urandom; req_data = $urandom;
        tick(3);
        check_zero("rst");
        req = '0;
        rst_n = 1'b1;
        tick(2);

        // Single write: requester 0, addr 2, data A5.
        req = 4'b0001; set_req(0, 2, 8'hA5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) req = '0;
            if (k <= 4) check("single_lat_d", 32'(lat_d), 32'hA5);
            check("single_lat_c", 32'(lat_c), (k == 2 || k == 3) ? 32'b0100 : 32'd0);
            check("single_ack", 32'(ack), (k == 5) ? 32'b0001 : 32'd0);
            check("single_busy", 32'(busy), 32'(k <= 5));
        end

        // Requester 2 withdraws and changes its inputs during SETUP.
        req = 4'b0100; set_req(2, 1, 8'h3C);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("wd_gid", 32'(grant_id), 32'd2);
                req = '0; set_req(2, 3, 8'hFF);
            end
            if (k <= 4) check("wd_lat_d", 32'(lat_d), 32'h3C);
            check("wd_lat_c", 32'(lat_c), (k == 2 || k == 3) ? 32'b0010 : 32'd0);
            check("wd_ack", 32'(ack), (k == 5) ? 32'b0100 : 32'd0);
        end

        // Reset asserted in the first PULSE cycle.
        req = 4'b0001; set_req(0, 3, 8'h5A);
        tick(1);
        req = '0;
        tick(1);
        check("mid_lat_c_pre", 32'(lat_c), 32'b1000);
        #1 rst_n = 1'b0;
        #1 check_zero("mid_async");
        clear_logs();
        tick(2);
        rst_n = 1'b1;
        req = 4'b1000; set_req(3, 0, 8'h77);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("mid_gid", 32'(grant_id), 32'd3);
                req = '0;
            end
            if (k == 4) check("mid_no_ack", 32'(ack_ids.size()), 32'd0);
            check("mid_lat_c", 32'(lat_c), (k == 2 || k == 3) ? 32'b0001 : 32'd0);
            check("mid_ack", 32'(ack), (k == 5) ? 32'b1000 : 32'd0);
        end

        // Contention: 0011 then 0110 -> grants 0,1,2,1.
        clear_logs();
        req = 4'b0011;
        set_req(0, 1, 8'h01); set_req(1, 2, 8'h02); set_req(2, 3, 8'h03);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) req = 4'b0110;
            if (k == 23) req = '0;
        end
        tick(2);
        check("cont_count", 32'(ack_ids.size()), 32'd4);
        if (ack_ids.size() == 4) begin
            check("cont_0", 32'(ack_ids[0]), 32'd0);
            check("cont_1", 32'(ack_ids[1]), 32'd1);
            check("cont_2", 32'(ack_ids[2]), 32'd2);
            check("cont_3", 32'(ack_ids[3]), 32'd1);
        end

        // Second reset with random inputs, then full round-robin from pointer 0.
        rst_n = 1'b0;
        req = NREQ'($urandom); req_addr = $urandom; req_data = $urandom;
        tick(2);
        check_zero("rst2");
        req = '0;
        rst_n = 1'b1;
        tick(1);
        clear_logs();
        for (int i = 0; i < NREQ; i++) set_req(i, 3 - i, 8'h10 + i);
        req = 4'b1111;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 29) req = '0;
        end
        tick(2);
        check("rr_count", 32'(ack_ids.size()), 32'd5);
        check("rr_pulses", 32'(pulses.size()), 32'd5);
        if (ack_ids.size() == 5 && pulses.size() == 5) begin
            for (int j = 0; j < 5; j++) begin
                check("rr_order", 32'(ack_ids[j]), 32'(j % NREQ));
                check("rr_pulse_addr", 32'(pulses[j]), 32'd1 << (3 - (j % NREQ)));
                if (j > 0) check("rr_spacing", 32'(ack_cyc[j] - ack_cyc[j-1]), 32'd6);
            end
        end

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
